// File: rtl/mc8051_agu_pipe_pkg.sv
// Shared definitions for the mc8051 address-generation pipeline:
// mode codes, bit-RAM base and skid-buffer state encoding.
package mc8051_agu_pipe_pkg;

  typedef enum logic [3:0] {
    AGU_M_RN     = 4'd0,
    AGU_M_RI     = 4'd1,
    AGU_M_PC     = 4'd2,
    AGU_M_IDX16  = 4'd3,
    AGU_M_IDX8   = 4'd4,
    AGU_M_SIDX8  = 4'd5,
    AGU_M_DPTR   = 4'd6,
    AGU_M_DPTR_A = 4'd7,
    AGU_M_PC_A   = 4'd8,
    AGU_M_BIT    = 4'd9,
    AGU_M_SX     = 4'd10,
    AGU_M_SP     = 4'd11,
    AGU_M_SP_INC = 4'd12,
    AGU_M_SP_DEC = 4'd13
  } agu_mode_e;

  localparam logic [7:0] AGU_BITRAM_BASE = 8'h20;

  // Sideband carried next to the address: bit_idx(3), is_sfr, carry, mode_err.
  localparam int unsigned AGU_META_W = 6;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/mc8051_agu_pipe_if.sv
// Request/result bus of the address-generation unit. The master side is the
// sequencer plus memory interface; the slave side is the AGU itself.
interface mc8051_agu_pipe_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BANK_W = 2
);

  logic              i_req_vld;
  logic              o_req_rdy;
  logic [3:0]        i_mode;
  logic [BANK_W-1:0] i_bank;
  logic [DATA_W-1:0] i_opc;
  logic [ADDR_W-1:0] i_pc;
  logic [ADDR_W-1:0] i_dptr;
  logic [DATA_W-1:0] i_acc;
  logic [DATA_W-1:0] i_sp;
  logic [DATA_W-1:0] i_buf0;
  logic [DATA_W-1:0] i_buf1;
  logic [DATA_W-1:0] i_sx;
  logic              i_flush;
  logic              o_addr_vld;
  logic              i_addr_rdy;
  logic [ADDR_W-1:0] o_addr;
  logic [2:0]        o_bit_idx;
  logic              o_is_sfr;
  logic              o_carry;
  logic              o_mode_err;

  modport master (
    output i_req_vld, i_mode, i_bank, i_opc, i_pc, i_dptr, i_acc, i_sp,
           i_buf0, i_buf1, i_sx, i_flush, i_addr_rdy,
    input  o_req_rdy, o_addr_vld, o_addr, o_bit_idx, o_is_sfr, o_carry,
           o_mode_err
  );

  modport slave (
    input  i_req_vld, i_mode, i_bank, i_opc, i_pc, i_dptr, i_acc, i_sp,
           i_buf0, i_buf1, i_sx, i_flush, i_addr_rdy,
    output o_req_rdy, o_addr_vld, o_addr, o_bit_idx, o_is_sfr, o_carry,
           o_mode_err
  );

endinterface

// File: rtl/mc8051_agu_pipe_skid_buf.sv
// Two-entry valid/ready skid buffer with registered ready, valid and data.
// The head register drives the output directly; the skid entry absorbs a stall.
module mc8051_skid_buf
  import mc8051_agu_pipe_pkg::*;
#(
  parameter int unsigned W = 22
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  skid_state_e  state;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         drain;

  assign accept = in_vld && in_rdy;
  assign drain  = out_vld && out_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SKID_EMPTY;
      in_rdy   <= 1'b0;
      out_vld  <= 1'b0;
      out_data <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      state   <= SKID_EMPTY;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
    end else begin
      case (state)
        SKID_EMPTY: begin
          in_rdy <= 1'b1;
          if (accept) begin
            out_data <= in_data;
            out_vld  <= 1'b1;
            state    <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && !drain) begin
            skid_q <= in_data;
            in_rdy <= 1'b0;
            state  <= SKID_TWO;
          end else if (drain && !accept) begin
            out_vld <= 1'b0;
            state   <= SKID_EMPTY;
          end else if (accept && drain) begin
            out_data <= in_data;
          end
        end
        SKID_TWO: begin
          // in_rdy is low here, so only a drain can happen.
          if (drain) begin
            out_data <= skid_q;
            in_rdy   <= 1'b1;
            state    <= SKID_ONE;
          end
        end
        default: begin
          state   <= SKID_EMPTY;
          in_rdy  <= 1'b1;
          out_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mc8051_agu_pipe.sv
// Registered address-generation unit: combinational mode decode and address
// arithmetic feeding a two-entry skid buffer that owns all outputs.
module mc8051_agu_pipe
  import mc8051_agu_pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BANK_W = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  mc8051_agu_pipe_if.slave   bus
);

  localparam int unsigned PAY_W = ADDR_W + AGU_META_W;
  localparam int unsigned SUM_W = ADDR_W + 1;

  logic [ADDR_W-1:0] addr_c;
  logic [2:0]        idx_c;
  logic              sfr_c;
  logic              carry_c;
  logic              err_c;
  logic [SUM_W-1:0]  sum_c;
  logic [DATA_W-1:0] sp_inc_c;
  logic [PAY_W-1:0]  pay_in;
  logic [PAY_W-1:0]  pay_out;
  logic              unused_opc_hi;

  assign unused_opc_hi = ^bus.i_opc[DATA_W-1:3];

  // SP_INC wraps inside DATA_W and never reports a carry.
  assign sp_inc_c = bus.i_sp + DATA_W'(1);

  always_comb begin
    addr_c  = '0;
    idx_c   = '0;
    sfr_c   = 1'b0;
    carry_c = 1'b0;
    err_c   = 1'b0;
    sum_c   = '0;
    case (bus.i_mode)
      AGU_M_RN:     addr_c = ADDR_W'({bus.i_bank, bus.i_opc[2:0]});
      AGU_M_RI:     addr_c = ADDR_W'({bus.i_bank, 2'b00, bus.i_opc[0]});
      AGU_M_PC:     addr_c = bus.i_pc;
      AGU_M_IDX16:  addr_c = ADDR_W'({bus.i_buf1, bus.i_buf0});
      AGU_M_IDX8: begin
        addr_c = ADDR_W'(bus.i_buf0);
        sfr_c  = bus.i_buf0[7];
      end
      AGU_M_SIDX8: begin
        addr_c = ADDR_W'(bus.i_buf1);
        sfr_c  = bus.i_buf1[7];
      end
      AGU_M_DPTR:   addr_c = bus.i_dptr;
      AGU_M_DPTR_A: begin
        sum_c   = {1'b0, bus.i_dptr} + SUM_W'(bus.i_acc);
        addr_c  = sum_c[ADDR_W-1:0];
        carry_c = sum_c[ADDR_W];
      end
      AGU_M_PC_A: begin
        sum_c   = {1'b0, bus.i_pc} + SUM_W'(bus.i_acc);
        addr_c  = sum_c[ADDR_W-1:0];
        carry_c = sum_c[ADDR_W];
      end
      AGU_M_BIT: begin
        idx_c = bus.i_buf0[2:0];
        if (!bus.i_buf0[7]) begin
          addr_c = ADDR_W'(AGU_BITRAM_BASE + {4'b0000, bus.i_buf0[6:3]});
        end else begin
          addr_c = ADDR_W'({bus.i_buf0[7:3], 3'b000});
          sfr_c  = 1'b1;
        end
      end
      AGU_M_SX:     addr_c = ADDR_W'(bus.i_sx);
      AGU_M_SP:     addr_c = ADDR_W'(bus.i_sp);
      AGU_M_SP_INC: addr_c = ADDR_W'(sp_inc_c);
      AGU_M_SP_DEC: addr_c = ADDR_W'(bus.i_sp);
      default:      err_c  = 1'b1;
    endcase
  end

  assign pay_in = {addr_c, idx_c, sfr_c, carry_c, err_c};

  mc8051_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .flush    (bus.i_flush),
    .in_vld   (bus.i_req_vld),
    .in_rdy   (bus.o_req_rdy),
    .in_data  (pay_in),
    .out_vld  (bus.o_addr_vld),
    .out_rdy  (bus.i_addr_rdy),
    .out_data (pay_out)
  );

  assign {bus.o_addr, bus.o_bit_idx, bus.o_is_sfr, bus.o_carry, bus.o_mode_err} = pay_out;

endmodule

// File: tb/tb_mc8051_agu_pipe.sv
// Bench for mc8051_agu_pipe: directed steps plus random traffic checked
// against a queue-based model of buffered results.
module tb_mc8051_agu_pipe;
  import mc8051_agu_pipe_pkg::*;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BANK_W = 2;

  typedef struct packed {
    logic [15:0] addr;
    logic [2:0]  idx;
    logic        sfr;
    logic        carry;
    logic        err;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc8051_agu_pipe_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANK_W(BANK_W)) bus ();

  mc8051_agu_pipe #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANK_W(BANK_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  res_t q[$];
  bit   in_reset = 1'b1;
  bit   last_vld = 1'b0;
  int   passes   = 0;
  int   total    = 0;
  int   done_cnt = 0;
  int   accepts  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected result straight from the mode table, in plain integer arithmetic.
  function automatic res_t ref_calc(int mode, int bank, int opc, int pc, int dptr,
                                    int acc, int sp, int b0, int b1, int sx);
    res_t r;
    int   s;
    r = '0;
    case (mode)
      0:  r.addr = 16'(bank * 8 + opc % 8);
      1:  r.addr = 16'(bank * 8 + opc % 2);
      2:  r.addr = 16'(pc);
      3:  r.addr = 16'(b1 * 256 + b0);
      4:  begin r.addr = 16'(b0); r.sfr = (b0 >= 128); end
      5:  begin r.addr = 16'(b1); r.sfr = (b1 >= 128); end
      6:  r.addr = 16'(dptr);
      7:  begin s = dptr + acc; r.addr = 16'(s % 65536); r.carry = (s >= 65536); end
      8:  begin s = pc + acc;   r.addr = 16'(s % 65536); r.carry = (s >= 65536); end
      9:  begin
            r.idx = 3'(b0 % 8);
            if (b0 < 128) r.addr = 16'(32 + (b0 / 8) % 16);
            else begin r.addr = 16'((b0 / 8) * 8); r.sfr = 1'b1; end
          end
      10: r.addr = 16'(sx);
      11: r.addr = 16'(sp);
      12: r.addr = 16'((sp + 1) % 256);
      13: r.addr = 16'(sp);
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  task automatic model_edge();
    bit rdy_before;
    rdy_before = !in_reset && (q.size() < 2);
    if (last_vld && bus.i_addr_rdy) done_cnt++;
    if (!rst_n) begin
      q.delete();
      in_reset = 1'b1;
    end else if (bus.i_flush) begin
      q.delete();
      in_reset = 1'b0;
    end else begin
      if (q.size() > 0 && bus.i_addr_rdy) void'(q.pop_front());
      if (bus.i_req_vld && rdy_before) begin
        q.push_back(ref_calc(int'(bus.i_mode), int'(bus.i_bank), int'(bus.i_opc),
                             int'(bus.i_pc), int'(bus.i_dptr), int'(bus.i_acc),
                             int'(bus.i_sp), int'(bus.i_buf0), int'(bus.i_buf1),
                             int'(bus.i_sx)));
        accepts++;
      end
      in_reset = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("req_rdy", 32'(bus.o_req_rdy), 32'(!in_reset && q.size() != 2));
    chk("addr_vld", 32'(bus.o_addr_vld), 32'(q.size() > 0));
    last_vld = bus.o_addr_vld;
    if (q.size() > 0) begin
      chk("addr", 32'(bus.o_addr), 32'(q[0].addr));
      chk("bit_idx", 32'(bus.o_bit_idx), 32'(q[0].idx));
      chk("is_sfr", 32'(bus.o_is_sfr), 32'(q[0].sfr));
      chk("carry", 32'(bus.o_carry), 32'(q[0].carry));
      chk("mode_err", 32'(bus.o_mode_err), 32'(q[0].err));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic rand_req();
    bus.i_mode = 4'($urandom_range(0, 15));
    bus.i_bank = 2'($urandom);
    bus.i_opc  = 8'($urandom);
    bus.i_pc   = 16'($urandom);
    bus.i_dptr = 16'($urandom);
    bus.i_acc  = 8'($urandom);
    bus.i_sp   = 8'($urandom);
    bus.i_buf0 = 8'($urandom);
    bus.i_buf1 = 8'($urandom);
    bus.i_sx   = 8'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"}, 32'(bus.o_addr_vld), 32'd0);
    chk({tag, "_rdy"}, 32'(bus.o_req_rdy), 32'd0);
    chk({tag, "_addr"}, 32'(bus.o_addr), 32'd0);
    chk({tag, "_idx"}, 32'(bus.o_bit_idx), 32'd0);
    chk({tag, "_sfr"}, 32'(bus.o_is_sfr), 32'd0);
    chk({tag, "_carry"}, 32'(bus.o_carry), 32'd0);
    chk({tag, "_err"}, 32'(bus.o_mode_err), 32'd0);
  endtask

  initial begin
    int cyc;
    int prev_acc;
    logic [15:0] held;

    rand_req();
    bus.i_req_vld  = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_addr_rdy = 1'b1;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // RN, bank 2, opc 0xEB
    rand_req();
    bus.i_mode = AGU_M_RN; bus.i_bank = 2'd2; bus.i_opc = 8'hEB;
    bus.i_req_vld = 1'b1;
    tick();
    chk("rn_addr", 32'(bus.o_addr), 32'h13);
    chk("rn_idx", 32'(bus.o_bit_idx), 32'd0);
    chk("rn_sfr", 32'(bus.o_is_sfr), 32'd0);

    // BIT in bit RAM, then BIT in SFR space, back to back
    rand_req();
    bus.i_mode = AGU_M_BIT; bus.i_buf0 = 8'h0D;
    tick();
    chk("bit_ram_addr", 32'(bus.o_addr), 32'h21);
    chk("bit_ram_idx", 32'(bus.o_bit_idx), 32'd5);
    rand_req();
    bus.i_mode = AGU_M_BIT; bus.i_buf0 = 8'hE7;
    tick();
    chk("bit_sfr_addr", 32'(bus.o_addr), 32'hE0);
    chk("bit_sfr_idx", 32'(bus.o_bit_idx), 32'd7);
    chk("bit_sfr_flag", 32'(bus.o_is_sfr), 32'd1);

    // DPTR_A overflow and SP_INC wrap
    rand_req();
    bus.i_mode = AGU_M_DPTR_A; bus.i_dptr = 16'hFFF0; bus.i_acc = 8'h20;
    tick();
    chk("dptra_addr", 32'(bus.o_addr), 32'h0010);
    chk("dptra_carry", 32'(bus.o_carry), 32'd1);
    rand_req();
    bus.i_mode = AGU_M_SP_INC; bus.i_sp = 8'hFF;
    tick();
    chk("spinc_addr", 32'(bus.o_addr), 32'h0000);
    chk("spinc_carry", 32'(bus.o_carry), 32'd0);

    // Undefined mode, then a valid beat
    rand_req();
    bus.i_mode = 4'd15;
    tick();
    chk("m15_addr", 32'(bus.o_addr), 32'd0);
    chk("m15_err", 32'(bus.o_mode_err), 32'd1);
    rand_req();
    bus.i_mode = AGU_M_PC;
    tick();
    chk("after_m15_err", 32'(bus.o_mode_err), 32'd0);
    bus.i_req_vld = 1'b0;
    tick();

    // Stream of 8 with the consumer stalled for the first 3 cycles
    done_cnt = 0;
    cyc = 0;
    rand_req();
    while (cyc < 100 && done_cnt < 8) begin
      bus.i_addr_rdy = (cyc >= 3);
      bus.i_req_vld  = (accepts - prev_acc < 8) || (cyc == 0);
      if (cyc == 0) prev_acc = accepts;
      bus.i_req_vld  = (accepts - prev_acc < 8);
      tick();
      rand_req();
      if (cyc == 1) begin
        chk("stream_rdy_drop", 32'(bus.o_req_rdy), 32'd0);
        held = bus.o_addr;
      end
      if (cyc == 2) chk("stall_stable", 32'(bus.o_addr), 32'(held));
      cyc++;
    end
    chk("stream_count", 32'(done_cnt), 32'd8);
    bus.i_req_vld  = 1'b0;
    bus.i_addr_rdy = 1'b1;
    tick();

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      rand_req();
      bus.i_req_vld  = ($urandom_range(0, 3) != 0);
      bus.i_addr_rdy = ($urandom_range(0, 2) != 0);
      bus.i_flush    = ($urandom_range(0, 31) == 0);
      tick();
    end
    bus.i_flush    = 1'b0;
    bus.i_req_vld  = 1'b0;
    bus.i_addr_rdy = 1'b1;
    tick();
    tick();

    // Flush while full, with a request offered in the same cycle
    bus.i_addr_rdy = 1'b0;
    bus.i_req_vld  = 1'b1;
    rand_req();
    tick();
    rand_req();
    tick();
    chk("full_rdy", 32'(bus.o_req_rdy), 32'd0);
    rand_req();
    bus.i_flush = 1'b1;
    tick();
    chk("flush_vld", 32'(bus.o_addr_vld), 32'd0);
    chk("flush_rdy", 32'(bus.o_req_rdy), 32'd1);
    bus.i_flush    = 1'b0;
    bus.i_req_vld  = 1'b0;
    bus.i_addr_rdy = 1'b1;
    done_cnt = 0;
    tick();
    tick();
    chk("flush_no_result", 32'(done_cnt), 32'd0);

    // Reset while full
    bus.i_addr_rdy = 1'b0;
    bus.i_req_vld  = 1'b1;
    rand_req();
    tick();
    rand_req();
    tick();
    rand_req();
    rst_n = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst_n = 1'b1;
    bus.i_req_vld  = 1'b0;
    bus.i_addr_rdy = 1'b1;
    tick();
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
